prio_encoder_8to3: RTL and testbench

PRIO_ENCODER_8TO3 -- requirements
Module: prio_encoder_8to3

---
 rtl/prio_encoder_8to3_pkg.sv | 13 +
 rtl/prio_encoder_8to3_pick.sv | 32 +++
 rtl/prio_encoder_8to3.sv | 96 +++++++++
 tb/tb_prio_encoder_8to3.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/prio_encoder_8to3_pkg.sv
// Shared widths and the bit-index to code mapping used by the 8-to-3 encoder
// and its matching 3-to-8 decoder.
package prio_encoder_8to3_pkg;

  localparam int unsigned CODE_W = 3;
  localparam int unsigned REQ_W  = 8;

  // Request line i maps to code 7 - i (inverse of the decoder's code-to-line map).
  function automatic logic [CODE_W-1:0] bit_to_code(input logic [CODE_W-1:0] idx);
    return CODE_W'(REQ_W - 1) - idx;
  endfunction

endpackage

// File: rtl/prio_encoder_8to3_pick.sv
// Combinational priority pick over the pending vector; LOW_FIRST selects
// whether bit 0 or bit 7 wins.
module prio_pick8
  import prio_encoder_8to3_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic [REQ_W-1:0]  pending,
  output logic [CODE_W-1:0] idx_c,
  output logic              any_c
);

  // Scan toward the winning end so the last hit is the highest-priority bit.
  always_comb begin
    idx_c = '0;
    any_c = |pending;
    if (LOW_FIRST) begin
      for (int i = int'(REQ_W) - 1; i >= 0; i--) begin
        if (pending[i]) begin
          idx_c = CODE_W'(i);
        end
      end
    end else begin
      for (int i = 0; i < int'(REQ_W); i++) begin
        if (pending[i]) begin
          idx_c = CODE_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/prio_encoder_8to3.sv
// Registered 8-to-3 priority encoder with sticky request capture and a
// valid/ready output slot. Optional overflow flag under PRIO_ENC_OVF_EN.
module prio_encoder_8to3
  import prio_encoder_8to3_pkg::*;
#(
  parameter bit LOW_FIRST = 1'b0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_n,
  input  logic [REQ_W-1:0]  req,
  input  logic              ready,
`ifdef PRIO_ENC_OVF_EN
  input  logic              ovf_clr,
  output logic              ovf,
`endif
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic [REQ_W-1:0]  pending
);

  logic [CODE_W-1:0] pick_idx_c;
  logic              pick_any_c;
  logic              slot_free_c;
  logic              load_c;
  logic [REQ_W-1:0]  issue_mask_c;
  logic [REQ_W-1:0]  pending_nxt_c;

  prio_pick8 #(
    .LOW_FIRST (LOW_FIRST)
  ) u_pick (
    .pending (pending),
    .idx_c   (pick_idx_c),
    .any_c   (pick_any_c)
  );

  // Slot/issue decode; new requests are OR'd in after the clear so they win.
  always_comb begin
    slot_free_c   = 1'b0;
    load_c        = 1'b0;
    issue_mask_c  = '0;
    pending_nxt_c = pending;
    slot_free_c   = !valid || ready;
    load_c        = slot_free_c && !en_n && pick_any_c;
    if (load_c) begin
      issue_mask_c = REQ_W'(1) << pick_idx_c;
    end
    if (!en_n) begin
      pending_nxt_c = (pending & ~issue_mask_c) | req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= '0;
    end else begin
      pending <= pending_nxt_c;
    end
  end

  // Output slot: load on a free slot with work, drop valid on a free idle slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      code  <= '0;
      valid <= 1'b0;
    end else if (slot_free_c) begin
      if (load_c) begin
        code  <= bit_to_code(pick_idx_c);
        valid <= 1'b1;
      end else begin
        valid <= 1'b0;
      end
    end
  end

`ifdef PRIO_ENC_OVF_EN
  logic ovf_set_c;

  // A request landing on an already-pending bit that is not leaving this edge is lost.
  always_comb begin
    ovf_set_c = 1'b0;
    ovf_set_c = !en_n && (|(req & pending & ~issue_mask_c));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_set_c) begin
      ovf <= 1'b1;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_prio_encoder_8to3.sv
// Directed bench for prio_encoder_8to3 (LOW_FIRST = 0) with an expected-code
// scoreboard popped on every accepted handshake.
module tb_prio_encoder_8to3;

  logic       clk;
  logic       rst_n;
  logic       en_n;
  logic [7:0] req;
  logic       ready;
  logic [2:0] code;
  logic       valid;
  logic [7:0] pending;
`ifdef PRIO_ENC_OVF_EN
  logic       ovf_clr;
  logic       ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  logic [2:0] exp_q[$];

  prio_encoder_8to3 #(.LOW_FIRST(1'b0)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_n    (en_n),
    .req     (req),
    .ready   (ready),
`ifdef PRIO_ENC_OVF_EN
    .ovf_clr (ovf_clr),
    .ovf     (ovf),
`endif
    .code    (code),
    .valid   (valid),
    .pending (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: score an accept about to happen, then step to 1 time unit past the edge.
  task automatic tick();
    logic [2:0] exp;
    if (valid === 1'b1 && ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_accept", 8'(code), 8'hxx);
      end else begin
        exp = exp_q.pop_front();
        chk("sb_code", 8'(code), 8'(exp));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    clk   = 1'b0;
    rst_n = 1'b0;
    en_n  = 1'b0;
    req   = 8'h00;
    ready = 1'b0;
`ifdef PRIO_ENC_OVF_EN
    ovf_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    chk("rst_code", 8'(code), 8'h00);
    chk("rst_valid", 8'(valid), 8'h00);
    chk("rst_pending", pending, 8'h00);
    rst_n = 1'b1;

    // Single request: capture on edge N, issue on N+1
    ready = 1'b1; req = 8'h80; exp_q.push_back(3'd0);
    tick();
    chk("t1_cap_pending", pending, 8'h80);
    chk("t1_cap_valid", 8'(valid), 8'h00);
    req = 8'h00;
    tick();
    chk("t1_valid", 8'(valid), 8'h01);
    chk("t1_code", 8'(code), 8'h00);
    chk("t1_pending", pending, 8'h00);
    tick();
    chk("t1_idle", 8'(valid), 8'h00);

    // Two requests issue back-to-back, high bit first
    req = 8'h81; exp_q.push_back(3'd0); exp_q.push_back(3'd7);
    tick();
    req = 8'h00;
    tick();
    chk("t2_code0", 8'(code), 8'h00);
    chk("t2_pending0", pending, 8'h01);
    tick();
    chk("t2_code7", 8'(code), 8'h07);
    chk("t2_valid7", 8'(valid), 8'h01);
    tick();
    chk("t2_idle", 8'(valid), 8'h00);

    // Backpressure hold with all requests asserted
    ready = 1'b0; req = 8'hFF; exp_q.push_back(3'd0);
    tick();
    req = 8'h00;
    tick();
    chk("t3_code", 8'(code), 8'h00);
    chk("t3_pending_minus", pending, 8'h7F);
    req = 8'hFF;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("t3_hold_code", 8'(code), 8'h00);
      chk("t3_hold_valid", 8'(valid), 8'h01);
    end
    // bit 7 re-arrived during the hold
    chk("t3_pending_refill", pending, 8'hFF);
    for (int c = 0; c < 8; c++) exp_q.push_back(3'(c));
    req = 8'h00; ready = 1'b1;
    for (int k = 0; k < 20 && exp_q.size() != 0; k++) tick();
    chk("t3_drain_left", 8'(exp_q.size()), 8'h00);
    tick();
    chk("t3_drain_idle", 8'(valid), 8'h00);
    chk("t3_drain_pending", pending, 8'h00);

    // Disabled block ignores requests
    en_n = 1'b1; req = 8'h10;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("t4_dis_pending", pending, 8'h00);
      chk("t4_dis_valid", 8'(valid), 8'h00);
    end
    en_n = 1'b0; exp_q.push_back(3'd3);
    tick();
    req = 8'h00;
    tick();
    chk("t4_code", 8'(code), 8'h03);
    chk("t4_valid", 8'(valid), 8'h01);
    tick();
    chk("t4_idle", 8'(valid), 8'h00);

    // Accept while disabled completes; reload waits for enable
    ready = 1'b0; req = 8'h03; exp_q.push_back(3'd6); exp_q.push_back(3'd7);
    tick();
    req = 8'h00;
    tick();
    chk("t5_code6", 8'(code), 8'h06);
    en_n = 1'b1; ready = 1'b1;
    tick();
    chk("t5_dis_valid", 8'(valid), 8'h00);
    chk("t5_dis_pending", pending, 8'h01);
    tick();
    chk("t5_dis_valid2", 8'(valid), 8'h00);
    en_n = 1'b0;
    tick();
    chk("t5_code7", 8'(code), 8'h07);
    tick();
    chk("t5_idle", 8'(valid), 8'h00);

    // Asynchronous reset mid-transaction
    ready = 1'b0; req = 8'h1C; exp_q.push_back(3'd3);
    tick();
    req = 8'h00;
    tick();
    chk("t6_pre_valid", 8'(valid), 8'h01);
    chk("t6_pre_pending", pending, 8'h0C);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_code", 8'(code), 8'h00);
    chk("t6_rst_valid", 8'(valid), 8'h00);
    chk("t6_rst_pending", pending, 8'h00);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1; ready = 1'b1;
    tick();
    chk("t6_post_valid", 8'(valid), 8'h00);

`ifdef PRIO_ENC_OVF_EN
    // Repeated request on a pending bit sets the sticky overflow flag
    ready = 1'b0; req = 8'h04; exp_q.push_back(3'd5); exp_q.push_back(3'd5);
    tick();
    chk("t7_no_ovf_cap", 8'(ovf), 8'h00);
    tick();
    chk("t7_no_ovf_issue", 8'(ovf), 8'h00);
    tick();
    chk("t7_ovf_set", 8'(ovf), 8'h01);
    req = 8'h00;
    tick();
    chk("t7_ovf_sticky", 8'(ovf), 8'h01);
    ovf_clr = 1'b1;
    tick();
    chk("t7_ovf_clr", 8'(ovf), 8'h00);
    ovf_clr = 1'b0; ready = 1'b1;
    for (int k = 0; k < 10 && exp_q.size() != 0; k++) tick();
    chk("t7_drain_left", 8'(exp_q.size()), 8'h00);
`endif

    chk("end_queue_empty", 8'(exp_q.size()), 8'h00);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
